// File: rtl/pwr_switch_ack_emu_pkg.sv
// Shared types and constants for the power-switch acknowledge emulator.
// Optional build macro: PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN (sticky abort flags).
package pwr_switch_ack_emu_pkg;

  // Per-channel switch state; ack is high in ON and RAMP_DOWN.
  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } pwr_sw_state_e;

  // Ack latency used by testharness tie-offs of unused switch channels.
  localparam int unsigned DEFAULT_SWITCH_ACK_LATENCY = 15;

endpackage

// File: rtl/pwr_switch_chan.sv
// One emulated power switch: a four-state FSM plus a ramp counter that
// answers a switch request with an acknowledge after a runtime latency.
// Optional build macro: PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN (exports abort events).
module pwr_switch_chan
  import pwr_switch_ack_emu_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter logic        RST_ACK = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             switch_i,
  input  logic [CNT_W-1:0] lat_on_i,
  input  logic [CNT_W-1:0] lat_off_i,
  input  logic             freeze_i,
`ifdef PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN
  output logic             abort_evt_o,
`endif
  output logic             ack_o,
  output logic             busy_o
);

  pwr_sw_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, busy_q;

  // A latency of 0 behaves as 1; the counter is loaded with Leff-1 so that
  // the ramp completes exactly Leff edges after the request edge.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [CNT_W-1:0] lat);
    return (lat == '0) ? '0 : lat - 1'b1;
  endfunction

  // Next-state and counter update; abort beats freeze, freeze beats countdown.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      OFF: begin
        if (switch_i) begin
          state_d = RAMP_UP;
          cnt_d   = lat_m1(lat_on_i);
        end
      end
      RAMP_UP: begin
        if (!switch_i) begin
          state_d = OFF;
          cnt_d   = '0;
        end else if (!freeze_i) begin
          if (cnt_q == '0) state_d = ON;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ON: begin
        if (!switch_i) begin
          state_d = RAMP_DOWN;
          cnt_d   = lat_m1(lat_off_i);
        end
      end
      RAMP_DOWN: begin
        if (switch_i) begin
          state_d = ON;
          cnt_d   = '0;
        end else if (!freeze_i) begin
          if (cnt_q == '0) state_d = OFF;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; ack and busy are registered from the next state so no
  // input reaches an output combinationally.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst_i) begin
      state_q <= RST_ACK ? ON : OFF;
      cnt_q   <= '0;
      ack_q   <= RST_ACK;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_d == ON) || (state_d == RAMP_DOWN);
      busy_q  <= (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
    end
  end

  assign ack_o  = ack_q;
  assign busy_o = busy_q;

`ifdef PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN
  // A ramp is aborted when the request flips back before completion.
  assign abort_evt_o = ((state_q == RAMP_UP) && !switch_i) ||
                       ((state_q == RAMP_DOWN) && switch_i);
`endif

endmodule

// File: rtl/pwr_switch_ack_emu.sv
// Multi-channel power-switch acknowledge emulator for testharnesses.
// Each channel is an independent pwr_switch_chan; this level only slices
// the packed latency buses and, optionally, keeps sticky abort flags.
// Optional build macro: PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN (abort_clr_i / abort_o).
module pwr_switch_ack_emu
  import pwr_switch_ack_emu_pkg::*;
#(
  parameter int unsigned       NUM_CH  = 4,
  parameter int unsigned       CNT_W   = 8,
  parameter logic [NUM_CH-1:0] RST_ACK = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       switch_i,
  input  logic [NUM_CH*CNT_W-1:0] lat_on_i,
  input  logic [NUM_CH*CNT_W-1:0] lat_off_i,
  input  logic                    freeze_i,
`ifdef PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN
  input  logic                    abort_clr_i,
  output logic [NUM_CH-1:0]       abort_o,
`endif
  output logic [NUM_CH-1:0]       switch_ack_o,
  output logic [NUM_CH-1:0]       busy_o
);

`ifdef PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN
  logic [NUM_CH-1:0] abort_evt;
  logic [NUM_CH-1:0] abort_q;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwr_switch_chan #(
      .CNT_W   (CNT_W),
      .RST_ACK (RST_ACK[c])
    ) u_chan (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .switch_i    (switch_i[c]),
      .lat_on_i    (lat_on_i[c*CNT_W +: CNT_W]),
      .lat_off_i   (lat_off_i[c*CNT_W +: CNT_W]),
      .freeze_i    (freeze_i),
`ifdef PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN
      .abort_evt_o (abort_evt[c]),
`endif
      .ack_o       (switch_ack_o[c]),
      .busy_o      (busy_o[c])
    );

`ifdef PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN
    // Announce each aborted ramp in the simulation log.
    always_ff @(posedge clk_i) begin
      if (!rst_i && abort_evt[c]) $warning("pwr_switch_ack_emu: ramp abort on channel %0d", c);
    end
`endif
  end

`ifdef PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN
  // Sticky abort flags; a new abort in the clearing cycle survives the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) abort_q <= '0;
    else       abort_q <= abort_evt | (abort_clr_i ? '0 : abort_q);
  end

  assign abort_o = abort_q;
`endif

endmodule

// File: tb/tb_pwr_switch_ack_emu.sv
// Directed testbench for pwr_switch_ack_emu (NUM_CH=4, CNT_W=8, RST_ACK=4'b0101).
// Abort-flag checks are compiled in with PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN.
module tb_pwr_switch_ack_emu;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       sw;
  logic [NUM_CH*CNT_W-1:0] lat_on;
  logic [NUM_CH*CNT_W-1:0] lat_off;
  logic                    freeze;
  logic [NUM_CH-1:0]       ack;
  logic [NUM_CH-1:0]       busy;
`ifdef PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN
  logic                    abort_clr;
  logic [NUM_CH-1:0]       abort;
`endif

  int total = 0;
  int bad   = 0;
  int rise [NUM_CH];

  pwr_switch_ack_emu #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .RST_ACK (4'b0101)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .switch_i     (sw),
    .lat_on_i     (lat_on),
    .lat_off_i    (lat_off),
    .freeze_i     (freeze),
`ifdef PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN
    .abort_clr_i  (abort_clr),
    .abort_o      (abort),
`endif
    .switch_ack_o (ack),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled at negedges.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    sw      = 4'b0101;
    lat_on  = '0;
    lat_off = '0;
    freeze  = 1'b0;
`ifdef PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN
    abort_clr = 1'b0;
`endif
    cyc(3);
    check("rst_ack", ack, 4'b0101);
    check("rst_busy", busy, 4'b0000);
`ifdef PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN
    check("rst_abort", abort, 4'b0000);
`endif
    rst = 1'b0;
    cyc(1);
    check("idle_ack", ack, 4'b0101);

    // Ramp-down of ch0 with lat_off=3: ack falls 3 edges after the request.
    lat_off[0*CNT_W +: CNT_W] = 8'd3;
    sw[0] = 1'b0;
    cyc(1);
    check("off_busy", busy, 4'b0001);
    check("off_ack_hold", ack, 4'b0101);
    cyc(2);
    check("off_ack_t2", ack[0], 1'b1);
    cyc(1);
    check("off_ack_t3", ack[0], 1'b0);
    check("off_busy_end", busy[0], 1'b0);

    // Basic ramp-up of ch0 with lat_on=15.
    lat_on[0*CNT_W +: CNT_W] = 8'd15;
    sw[0] = 1'b1;
    cyc(1);
    check("on_busy_t0", busy, 4'b0001);
    check("on_ack_t0", ack, 4'b0100);
    cyc(14);
    check("on_busy_t14", busy[0], 1'b1);
    check("on_ack_t14", ack[0], 1'b0);
    cyc(1);
    check("on_ack_t15", ack[0], 1'b1);
    check("on_busy_t15", busy[0], 1'b0);

    // Zero latency on ch1 behaves as one cycle.
    lat_on[1*CNT_W +: CNT_W] = 8'd0;
    sw[1] = 1'b1;
    cyc(1);
    check("zero_busy_t0", busy[1], 1'b1);
    check("zero_ack_t0", ack[1], 1'b0);
    cyc(1);
    check("zero_ack_t1", ack[1], 1'b1);
    check("zero_busy_t1", busy[1], 1'b0);

    // Abort of a ch3 ramp-up at edge t0+4.
    lat_on[3*CNT_W +: CNT_W] = 8'd10;
    sw[3] = 1'b1;
    cyc(4);
    check("abort_busy_pre", busy[3], 1'b1);
    sw[3] = 1'b0;
    cyc(1);
    check("abort_busy", busy[3], 1'b0);
    check("abort_ack", ack[3], 1'b0);
    cyc(12);
    check("abort_ack_late", ack[3], 1'b0);
`ifdef PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN
    check("abort_flag", abort, 4'b1000);
    abort_clr = 1'b1;
    cyc(1);
    abort_clr = 1'b0;
    check("abort_clr", abort, 4'b0000);
`endif

    // Freeze of three cycles during a 5-cycle ramp: ack at t0+8.
    lat_on[3*CNT_W +: CNT_W] = 8'd5;
    sw[3] = 1'b1;
    cyc(2);
    freeze = 1'b1;
    cyc(3);
    check("frz_busy", busy[3], 1'b1);
    freeze = 1'b0;
    cyc(3);
    check("frz_ack_t7", ack[3], 1'b0);
    cyc(1);
    check("frz_ack_t8", ack[3], 1'b1);

    // Abort during freeze is still taken immediately (ramp-down back to ON).
    lat_off[3*CNT_W +: CNT_W] = 8'd10;
    sw[3] = 1'b0;
    cyc(2);
    check("frz_abort_pre", {busy[3], ack[3]}, 2'b11);
    freeze = 1'b1;
    sw[3]  = 1'b1;
    cyc(1);
    check("frz_abort_busy", busy[3], 1'b0);
    check("frz_abort_ack", ack[3], 1'b1);
    freeze = 1'b0;
`ifdef PWR_SWITCH_ACK_EMU_ABORT_FLAG_EN
    check("frz_abort_flag", abort[3], 1'b1);
    abort_clr = 1'b1;
    cyc(1);
    abort_clr = 1'b0;
`endif

    // Reset mid-ramp: ch1 ramping up, ch2 ramping down.
    lat_off[1*CNT_W +: CNT_W] = 8'd1;
    sw[1] = 1'b0;
    cyc(2);
    check("pre_rst_ch1_off", ack[1], 1'b0);
    lat_on[1*CNT_W +: CNT_W]  = 8'd20;
    lat_off[2*CNT_W +: CNT_W] = 8'd20;
    sw[1] = 1'b1;
    sw[2] = 1'b0;
    cyc(3);
    check("pre_rst_busy", busy, 4'b0110);
    check("pre_rst_ack", ack, 4'b1101);
    rst = 1'b1;
    sw  = 4'b0101;
    cyc(1);
    check("mid_rst_ack", ack, 4'b0101);
    check("mid_rst_busy", busy, 4'b0000);
    rst   = 1'b0;
    sw[1] = 1'b1;
    cyc(20);
    check("post_rst_t19", {busy[1], ack[1]}, 2'b10);
    cyc(1);
    check("post_rst_t20", ack[1], 1'b1);

    // Concurrency: all channels requested together, lat_on changed afterwards.
    sw      = 4'b0000;
    lat_off = 32'h01010101;
    cyc(3);
    check("conc_idle_ack", ack, 4'b0000);
    check("conc_idle_busy", busy, 4'b0000);
    lat_on = {8'd255, 8'd7, 8'd2, 8'd1};
    sw     = 4'b1111;
    for (int i = 0; i < NUM_CH; i++) rise[i] = -1;
    for (int n = 1; n <= 300; n++) begin
      cyc(1);
      if (n == 1) lat_on = 32'h03030303;
      for (int i = 0; i < NUM_CH; i++)
        if (ack[i] && rise[i] < 0) rise[i] = n - 1;
    end
    check("conc_lat_ch0", rise[0], 32'd1);
    check("conc_lat_ch1", rise[1], 32'd2);
    check("conc_lat_ch2", rise[2], 32'd7);
    check("conc_lat_ch3", rise[3], 32'd255);
    check("conc_busy_end", busy, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
